load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/load_store_unit_if.sv | 47 ++++
 rtl/lsu_align.sv | 56 +++++
 rtl/load_store_unit.sv | 169 ++++++++++++++++
 tb/tb_load_store_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: size codes, FSM states,
// byte-enable patterns and the latched request record.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned BE_N   = XLEN / 8;
    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [BE_N-1:0] BE_NONE = 4'b0000;
    localparam logic [BE_N-1:0] BE_B    = 4'b0001;
    localparam logic [BE_N-1:0] BE_H_LO = 4'b0011;
    localparam logic [BE_N-1:0] BE_H_HI = 4'b1100;
    localparam logic [BE_N-1:0] BE_W    = 4'b1111;

    // Request fields still needed after the handshake (address/data live in the dmem regs)
    typedef struct packed {
        logic            we;
        size_e           size;
        logic            uns;
        logic [1:0]      addr_lo;
        logic [RD_W-1:0] rd;
    } lsu_req_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Request, data-memory and register-file-side signals of the load/store unit.
interface load_store_unit_if;
    import lsu_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [RD_W-1:0] req_rd;

    logic            dmem_req;
    logic            dmem_we;
    logic [BE_N-1:0] dmem_be;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;

    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;
    logic [RD_W-1:0] rsp_rd;
    logic            wr_en_rf;

    logic            misalign;
    logic            timeout_err;
    logic            busy;

    // slave: the load/store unit itself
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        input  dmem_ack, dmem_rdata,
        output req_ready, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output rsp_valid, rsp_data, rsp_rd, wr_en_rf, misalign, timeout_err, busy
    );

    // master: control unit plus data memory
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        output dmem_ack, dmem_rdata,
        input  req_ready, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  rsp_valid, rsp_data, rsp_rd, wr_en_rf, misalign, timeout_err, busy
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: alignment check, byte enables, store replication
// and load extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  size_e           st_size,
    input  logic [1:0]      st_addr_lo,
    input  logic [XLEN-1:0] st_wdata,
    input  size_e           ld_size,
    input  logic [1:0]      ld_addr_lo,
    input  logic            ld_uns,
    input  logic [XLEN-1:0] ld_rdata,
    output logic            misaligned_c,
    output logic [BE_N-1:0] be_c,
    output logic [XLEN-1:0] wdata_c,
    output logic [XLEN-1:0] ld_data_c
);

    logic [XLEN-1:0] ld_shift;

    always_comb begin
        misaligned_c = 1'b0;
        be_c         = BE_NONE;
        wdata_c      = st_wdata;
        unique case (st_size)
            SIZE_B: begin
                be_c    = BE_N'(BE_B << st_addr_lo);
                wdata_c = {4{st_wdata[7:0]}};
            end
            SIZE_H: begin
                misaligned_c = st_addr_lo[0];
                be_c         = st_addr_lo[1] ? BE_H_HI : BE_H_LO;
                wdata_c      = {2{st_wdata[15:0]}};
            end
            SIZE_W: begin
                misaligned_c = (st_addr_lo != 2'b00);
                be_c         = BE_W;
            end
            default: misaligned_c = 1'b1;
        endcase
    end

    // The addressed byte/half is moved down to bit 0 before extension
    always_comb begin
        ld_shift  = ld_rdata >> {ld_addr_lo, 3'b000};
        ld_data_c = ld_rdata;
        unique case (ld_size)
            SIZE_B:  ld_data_c = ld_uns ? {24'd0, ld_shift[7:0]}
                                        : {{24{ld_shift[7]}}, ld_shift[7:0]};
            SIZE_H:  ld_data_c = ld_uns ? {16'd0, ld_shift[15:0]}
                                        : {{16{ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data_c = ld_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, runs a single data-memory
// access with timeout, and returns extracted load data to the register file.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  bus
);

    state_e              state, state_nxt;
    lsu_req_t            cur, cur_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;

    logic                req_ready_q, req_ready_nxt;
    logic                busy_q, busy_nxt;
    logic                dmem_req_q, dmem_req_nxt;
    logic                dmem_we_q, dmem_we_nxt;
    logic [BE_N-1:0]     dmem_be_q, dmem_be_nxt;
    logic [XLEN-1:0]     dmem_addr_q, dmem_addr_nxt;
    logic [XLEN-1:0]     dmem_wdata_q, dmem_wdata_nxt;
    logic                rsp_valid_q, rsp_valid_nxt;
    logic [XLEN-1:0]     rsp_data_q, rsp_data_nxt;
    logic [RD_W-1:0]     rsp_rd_q, rsp_rd_nxt;
    logic                wr_en_q, wr_en_nxt;
    logic                misalign_q, misalign_nxt;
    logic                timeout_q, timeout_nxt;

    logic                misaligned_c;
    logic [BE_N-1:0]     be_c;
    logic [XLEN-1:0]     wdata_c;
    logic [XLEN-1:0]     ld_data_c;

    lsu_align u_align (
        .st_size      (size_e'(bus.req_size)),
        .st_addr_lo   (bus.req_addr[1:0]),
        .st_wdata     (bus.req_wdata),
        .ld_size      (cur.size),
        .ld_addr_lo   (cur.addr_lo),
        .ld_uns       (cur.uns),
        .ld_rdata     (bus.dmem_rdata),
        .misaligned_c (misaligned_c),
        .be_c         (be_c),
        .wdata_c      (wdata_c),
        .ld_data_c    (ld_data_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state;
        cur_nxt        = cur;
        wait_cnt_nxt   = wait_cnt;
        dmem_req_nxt   = dmem_req_q;
        dmem_we_nxt    = dmem_we_q;
        dmem_be_nxt    = dmem_be_q;
        dmem_addr_nxt  = dmem_addr_q;
        dmem_wdata_nxt = dmem_wdata_q;
        rsp_valid_nxt  = 1'b0;
        rsp_data_nxt   = rsp_data_q;
        rsp_rd_nxt     = rsp_rd_q;
        wr_en_nxt      = 1'b0;
        misalign_nxt   = 1'b0;
        timeout_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    cur_nxt.we      = bus.req_we;
                    cur_nxt.size    = size_e'(bus.req_size);
                    cur_nxt.uns     = bus.req_unsigned;
                    cur_nxt.addr_lo = bus.req_addr[1:0];
                    cur_nxt.rd      = bus.req_rd;
                    if (misaligned_c) begin
                        misalign_nxt = 1'b1;
                    end else begin
                        state_nxt      = ACCESS;
                        wait_cnt_nxt   = '0;
                        dmem_req_nxt   = 1'b1;
                        dmem_we_nxt    = bus.req_we;
                        dmem_be_nxt    = be_c;
                        dmem_addr_nxt  = {bus.req_addr[XLEN-1:2], 2'b00};
                        dmem_wdata_nxt = wdata_c;
                    end
                end
            end
            ACCESS: begin
                // Ack wins over a timeout landing in the same cycle
                if (bus.dmem_ack) begin
                    dmem_req_nxt = 1'b0;
                    if (cur.we) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_data_nxt  = ld_data_c;
                        rsp_rd_nxt    = cur.rd;
                        wr_en_nxt     = (cur.rd != '0);
                    end
                end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    dmem_req_nxt = 1'b0;
                    timeout_nxt  = 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        req_ready_nxt = (state_nxt == IDLE);
        busy_nxt      = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cur          <= '0;
            wait_cnt     <= '0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_be_q    <= BE_NONE;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_rd_q     <= '0;
            wr_en_q      <= 1'b0;
            misalign_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state        <= state_nxt;
            cur          <= cur_nxt;
            wait_cnt     <= wait_cnt_nxt;
            req_ready_q  <= req_ready_nxt;
            busy_q       <= busy_nxt;
            dmem_req_q   <= dmem_req_nxt;
            dmem_we_q    <= dmem_we_nxt;
            dmem_be_q    <= dmem_be_nxt;
            dmem_addr_q  <= dmem_addr_nxt;
            dmem_wdata_q <= dmem_wdata_nxt;
            rsp_valid_q  <= rsp_valid_nxt;
            rsp_data_q   <= rsp_data_nxt;
            rsp_rd_q     <= rsp_rd_nxt;
            wr_en_q      <= wr_en_nxt;
            misalign_q   <= misalign_nxt;
            timeout_q    <= timeout_nxt;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.busy        = busy_q;
    assign bus.dmem_req    = dmem_req_q;
    assign bus.dmem_we     = dmem_we_q;
    assign bus.dmem_be     = dmem_be_q;
    assign bus.dmem_addr   = dmem_addr_q;
    assign bus.dmem_wdata  = dmem_wdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_rd      = rsp_rd_q;
    assign bus.wr_en_rf    = wr_en_q;
    assign bus.misalign    = misalign_q;
    assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 4-cycle access timeout.
module tb_load_store_unit;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Presents one request for a single cycle; returns at the following negedge
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd);
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_rd       = rd;
        bus.req_valid    = 1'b1;
        step();
        bus.req_valid    = 1'b0;
    endtask

    task automatic ack_with(input logic [31:0] rdata);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = rdata;
        step();
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'h0;
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        rst              = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.req_rd       = 5'd0;
        bus.dmem_ack     = 1'b0;
        bus.dmem_rdata   = 32'h0;

        repeat (2) step();
        chk("rst_dmem_req",  32'(bus.dmem_req),    32'h0);
        chk("rst_busy",      32'(bus.busy),        32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid),   32'h0);
        chk("rst_be",        32'(bus.dmem_be),     32'h0);
        chk("rst_addr",      bus.dmem_addr,        32'h0);
        chk("rst_rsp_data",  bus.rsp_data,         32'h0);
        chk("rst_timeout",   32'(bus.timeout_err), 32'h0);
        rst = 1'b1;
        step();
        chk("idle_ready", 32'(bus.req_ready), 32'h1);

        // Signed byte load at 0x1003, ack on the second ACCESS cycle
        issue(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 5'd5);
        chk("lb_req",   32'(bus.dmem_req),  32'h1);
        chk("lb_addr",  bus.dmem_addr,      32'h0000_1000);
        chk("lb_we",    32'(bus.dmem_we),   32'h0);
        chk("lb_be",    32'(bus.dmem_be),   32'h8);
        chk("lb_ready", 32'(bus.req_ready), 32'h0);
        chk("lb_busy",  32'(bus.busy),      32'h1);
        step();
        chk("lb_req2",  32'(bus.dmem_req),  32'h1);
        chk("lb_nrsp",  32'(bus.rsp_valid), 32'h0);
        ack_with(32'h80FF_1234);
        chk("lb_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("lb_rsp_data",  bus.rsp_data,       32'hFFFF_FF80);
        chk("lb_rsp_rd",    32'(bus.rsp_rd),    32'h5);
        chk("lb_wr_en",     32'(bus.wr_en_rf),  32'h1);
        chk("lb_req_drop",  32'(bus.dmem_req),  32'h0);
        step();
        chk("lb_rsp_once", 32'(bus.rsp_valid), 32'h0);
        chk("lb_wr_once",  32'(bus.wr_en_rf),  32'h0);
        chk("lb_ready2",   32'(bus.req_ready), 32'h1);

        // Unsigned half load, rd=0 so no register write
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0, 5'd0);
        chk("lhu_be", 32'(bus.dmem_be), 32'hC);
        ack_with(32'hBEEF_0000);
        chk("lhu_valid", 32'(bus.rsp_valid), 32'h1);
        chk("lhu_data",  bus.rsp_data,       32'h0000_BEEF);
        chk("lhu_wr_en", 32'(bus.wr_en_rf),  32'h0);
        step();

        // Signed half load from the low lane
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0000, 32'h0, 5'd7);
        chk("lh_be", 32'(bus.dmem_be), 32'h3);
        ack_with(32'h1234_8001);
        chk("lh_data", bus.rsp_data,     32'hFFFF_8001);
        chk("lh_rd",   32'(bus.rsp_rd),  32'h7);
        step();

        // Word load passes through
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 5'd31);
        chk("lw_be", 32'(bus.dmem_be), 32'hF);
        ack_with(32'hDEAD_BEEF);
        chk("lw_data", bus.rsp_data, 32'hDEAD_BEEF);
        step();

        // Unsigned byte load from lane 1
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'h0, 5'd1);
        ack_with(32'h0000_9A00);
        chk("lbu_data", bus.rsp_data, 32'h0000_009A);
        step();

        // Byte store with junk in the upper data bits
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h1234_56AB, 5'd3);
        chk("sb_be",    32'(bus.dmem_be), 32'h2);
        chk("sb_wdata", bus.dmem_wdata,   32'hABAB_ABAB);
        chk("sb_addr",  bus.dmem_addr,    32'h0000_0100);
        chk("sb_we",    32'(bus.dmem_we), 32'h1);
        ack_with(32'h0);
        chk("sb_norsp", 32'(bus.rsp_valid), 32'h0);
        chk("sb_req0",  32'(bus.dmem_req),  32'h0);
        chk("sb_idle",  32'(bus.busy),      32'h0);
        step();
        chk("sb_norsp2", 32'(bus.rsp_valid), 32'h0);

        issue(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_CAFE, 5'd3);
        chk("sh_be",    32'(bus.dmem_be), 32'hC);
        chk("sh_wdata", bus.dmem_wdata,   32'hCAFE_CAFE);
        chk("sh_addr",  bus.dmem_addr,    32'h0000_0200);
        ack_with(32'h0);

        issue(1'b1, 2'b10, 1'b0, 32'h0000_030C, 32'h0123_4567, 5'd3);
        chk("sw_be",    32'(bus.dmem_be), 32'hF);
        chk("sw_wdata", bus.dmem_wdata,   32'h0123_4567);
        chk("sw_addr",  bus.dmem_addr,    32'h0000_030C);
        ack_with(32'h0);

        // Misaligned requests: word@6, illegal size, half@odd
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 5'd4);
        chk("mis_w_pulse", 32'(bus.misalign),  32'h1);
        chk("mis_w_req",   32'(bus.dmem_req),  32'h0);
        chk("mis_w_ready", 32'(bus.req_ready), 32'h1);
        chk("mis_w_busy",  32'(bus.busy),      32'h0);
        chk("mis_w_rsp",   32'(bus.rsp_valid), 32'h0);
        step();
        chk("mis_w_once",  32'(bus.misalign),  32'h0);
        chk("mis_w_req2",  32'(bus.dmem_req),  32'h0);
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 5'd4);
        chk("mis_x_pulse", 32'(bus.misalign), 32'h1);
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'h0, 5'd4);
        chk("mis_h_pulse", 32'(bus.misalign), 32'h1);
        chk("mis_h_req",   32'(bus.dmem_req), 32'h0);
        step();

        // No ack: four ACCESS cycles, then abort
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 5'd2);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("to_req_c%0d", i), 32'(bus.dmem_req),    32'h1);
            chk($sformatf("to_err_c%0d", i), 32'(bus.timeout_err), 32'h0);
            step();
        end
        chk("to_pulse", 32'(bus.timeout_err), 32'h1);
        chk("to_req0",  32'(bus.dmem_req),    32'h0);
        chk("to_idle",  32'(bus.busy),        32'h0);
        chk("to_norsp", 32'(bus.rsp_valid),   32'h0);
        chk("to_ready", 32'(bus.req_ready),   32'h1);
        step();
        chk("to_once", 32'(bus.timeout_err), 32'h0);
        ack_with(32'h5555_5555);
        chk("late_ack_norsp", 32'(bus.rsp_valid), 32'h0);
        chk("late_ack_idle",  32'(bus.busy),      32'h0);

        // Ack on the last allowed cycle completes the access
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0, 5'd6);
        repeat (3) step();
        ack_with(32'h0000_007F);
        chk("edge_no_to", 32'(bus.timeout_err), 32'h0);
        chk("edge_rsp",   32'(bus.rsp_valid),   32'h1);
        chk("edge_data",  bus.rsp_data,         32'h0000_007F);
        step();

        // Reset in the middle of an access, then a stray ack
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0050, 32'h0, 5'd9);
        chk("rm_req", 32'(bus.dmem_req), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("rm_req_async", 32'(bus.dmem_req), 32'h0);
        chk("rm_busy",      32'(bus.busy),     32'h0);
        chk("rm_addr",      bus.dmem_addr,     32'h0);
        chk("rm_be",        32'(bus.dmem_be),  32'h0);
        step();
        rst = 1'b1;
        ack_with(32'hFFFF_FFFF);
        chk("rm_norsp", 32'(bus.rsp_valid), 32'h0);
        chk("rm_req0",  32'(bus.dmem_req),  32'h0);
        chk("rm_data",  bus.rsp_data,       32'h0);
        step();
        chk("rm_norsp2", 32'(bus.rsp_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
